// File: rtl/register_bank_pkg.sv
// Shared widths, index/data types and the write-back request bundle for register_bank.
package register_bank_pkg;
  localparam int DATA_W   = 20;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam logic [3:0] OP_STORE = 4'b1100;

  typedef logic [ADDR_W-1:0] regIdx_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    logic    en;
    regIdx_t addr;
    word_t   data;
  } wbReq_t;

  function automatic logic [NUM_REGS-1:0] idxMask(input logic en, input regIdx_t idx);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (en) m[idx] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: per-register in-flight flags, set/clear arbitration and issue hazard detect.
// With REGBANK_WB_BYPASS_EN defined, a bit being cleared by write-back this cycle no longer stalls.
module reg_scoreboard
  import register_bank_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                issueValid,
  input  logic                issueWritesReg,
  input  regIdx_t             issueDest,
  input  regIdx_t             readAddrA,
  input  regIdx_t             readAddrB,
  input  logic                clearValid,
  input  regIdx_t             clearIdx,
  output logic                stall,
  output logic [NUM_REGS-1:0] busyVector
);
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] effBusy;
  logic [NUM_REGS-1:0] setMask;
  logic [NUM_REGS-1:0] clrMask;
  logic                accept;

  assign clrMask = idxMask(clearValid, clearIdx);

`ifdef REGBANK_WB_BYPASS_EN
  assign effBusy = busy & ~clrMask;
`else
  assign effBusy = busy;
`endif

  always_comb begin
    stall = 1'b0;
    if (!reset && issueValid)
      stall = effBusy[readAddrA] | effBusy[readAddrB] | (issueWritesReg & effBusy[issueDest]);
  end

  assign accept  = issueValid & ~stall & issueWritesReg;
  assign setMask = idxMask(accept, issueDest);

  // Set is applied after clear so a newly issued producer keeps ownership.
  genvar i;
  generate
    for (i = 0; i < NUM_REGS; i++) begin : gBusy
      always_ff @(posedge clock) begin
        if (reset)           busy[i] <= 1'b0;
        else if (setMask[i]) busy[i] <= 1'b1;
        else if (clrMask[i]) busy[i] <= 1'b0;
      end
    end
  endgenerate

  assign busyVector = reset ? '0 : busy;
endmodule

// File: rtl/register_bank.sv
// Architectural register file with write-back port, two combinational reads and issue scoreboard.
// Optional macro REGBANK_WB_BYPASS_EN enables same-cycle write-back to read forwarding.
module register_bank
  import register_bank_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                writeBackEnable,
  input  logic [ADDR_W-1:0]   writeBackAddress,
  input  logic [DATA_W-1:0]   writeBackData,
  input  logic [ADDR_W-1:0]   readAddrA,
  input  logic [ADDR_W-1:0]   readAddrB,
  output logic [DATA_W-1:0]   readDataA,
  output logic [DATA_W-1:0]   readDataB,
  input  logic                issueValid,
  input  logic                issueWritesReg,
  input  logic [ADDR_W-1:0]   issueDest,
  output logic                stall,
  output logic [NUM_REGS-1:0] busyVector
);
  wbReq_t                           wb;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs;
  logic [NUM_REGS-1:0]              wrMask;

  assign wb     = '{en: writeBackEnable, addr: writeBackAddress, data: writeBackData};
  assign wrMask = idxMask(wb.en, wb.addr);

  genvar i;
  generate
    for (i = 0; i < NUM_REGS; i++) begin : gReg
      always_ff @(posedge clock) begin
        if (reset)          regs[i] <= '0;
        else if (wrMask[i]) regs[i] <= wb.data;
      end
    end
  endgenerate

  // Reads are forced to zero during reset since the array only clears at the edge.
  always_comb begin
    readDataA = regs[readAddrA];
    readDataB = regs[readAddrB];
`ifdef REGBANK_WB_BYPASS_EN
    if (wb.en && wb.addr == readAddrA) readDataA = wb.data;
    if (wb.en && wb.addr == readAddrB) readDataB = wb.data;
`endif
    if (reset) begin
      readDataA = '0;
      readDataB = '0;
    end
  end

  reg_scoreboard uScoreboard (
    .clock         (clock),
    .reset         (reset),
    .issueValid    (issueValid),
    .issueWritesReg(issueWritesReg),
    .issueDest     (issueDest),
    .readAddrA     (readAddrA),
    .readAddrB     (readAddrB),
    .clearValid    (wb.en),
    .clearIdx      (wb.addr),
    .stall         (stall),
    .busyVector    (busyVector)
  );
endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank (expectations follow REGBANK_WB_BYPASS_EN).
module tb_register_bank;
  logic        clk = 1'b0;
  logic        reset;
  logic        writeBackEnable;
  logic [3:0]  writeBackAddress;
  logic [19:0] writeBackData;
  logic [3:0]  readAddrA, readAddrB;
  logic [19:0] readDataA, readDataB;
  logic        issueValid, issueWritesReg;
  logic [3:0]  issueDest;
  logic        stall;
  logic [15:0] busyVector;

  int checks = 0;
  int failures = 0;

`ifdef REGBANK_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  register_bank dut (
    .clock(clk), .reset(reset),
    .writeBackEnable(writeBackEnable), .writeBackAddress(writeBackAddress),
    .writeBackData(writeBackData),
    .readAddrA(readAddrA), .readAddrB(readAddrB),
    .readDataA(readDataA), .readDataB(readDataB),
    .issueValid(issueValid), .issueWritesReg(issueWritesReg), .issueDest(issueDest),
    .stall(stall), .busyVector(busyVector)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; combinational outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    writeBackEnable = 0; writeBackAddress = 0; writeBackData = 0;
    issueValid = 0; issueWritesReg = 0; issueDest = 0;
    readAddrA = 0; readAddrB = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick(); tick();
    reset = 1'b0;

    // Populate registers and one busy bit, then reset with a write pending.
    for (int i = 1; i < 16; i++) begin
      writeBackEnable = 1; writeBackAddress = 4'(i); writeBackData = 20'(i * 20'h01111);
      tick();
    end
    writeBackEnable = 0;
    issueValid = 1; issueWritesReg = 1; issueDest = 4'd9;
    tick();
    issueValid = 0;
    #1;
    check("preBusy9", 32'(busyVector), 32'h0200);
    check("preR1", 32'(readDataA), 32'h0);
    readAddrA = 4'd1; #1;
    check("preR1val", 32'(readDataA), 32'h01111);

    reset = 1; writeBackEnable = 1; writeBackAddress = 4'd1; writeBackData = 20'hFFFFF;
    issueValid = 1; issueWritesReg = 0; readAddrB = 4'd9;
    #1;
    check("rstReadA", 32'(readDataA), 32'h0);
    check("rstBusy", 32'(busyVector), 32'h0);
    check("rstStall", 32'(stall), 32'h0);
    tick(); tick();
    reset = 0; idle(); readAddrA = 4'd1; readAddrB = 4'd15; #1;
    check("postRstA", 32'(readDataA), 32'h0);
    check("postRstB", 32'(readDataB), 32'h0);
    check("postRstBusy", 32'(busyVector), 32'h0);

    // Plain write, visible next cycle; neighbour untouched.
    writeBackEnable = 1; writeBackAddress = 4'd3; writeBackData = 20'hABCDE;
    tick();
    writeBackEnable = 0; readAddrA = 4'd3; readAddrB = 4'd4; #1;
    check("wrR3", 32'(readDataA), 32'hABCDE);
    check("wrR4", 32'(readDataB), 32'h0);

    // RAW hazard on r5 until write-back.
    idle(); issueValid = 1; issueWritesReg = 1; issueDest = 4'd5; #1;
    check("issue5Stall", 32'(stall), 32'h0);
    tick();
    issueWritesReg = 0; issueDest = 0; readAddrB = 4'd5; #1;
    check("raw5Busy", 32'(busyVector), 32'h0020);
    check("raw5Stall", 32'(stall), 32'h1);
    tick(); #1;
    check("raw5Hold", 32'(stall), 32'h1);
    writeBackEnable = 1; writeBackAddress = 4'd5; writeBackData = 20'h55555; #1;
    check("raw5WbCycle", 32'(stall), 32'(!BYP));
    check("raw5WbData", 32'(readDataB), BYP ? 32'h55555 : 32'h0);
    tick();
    writeBackEnable = 0; #1;
    check("raw5After", 32'(stall), 32'h0);
    check("raw5Clear", 32'(busyVector), 32'h0);
    check("raw5Data", 32'(readDataB), 32'h55555);

    // WAW: second writer to a busy destination stalls and is not accepted.
    idle(); issueValid = 1; issueWritesReg = 1; issueDest = 4'd8;
    tick(); #1;
    check("waw8Stall", 32'(stall), 32'h1);
    tick(); idle();
    writeBackEnable = 1; writeBackAddress = 4'd8; writeBackData = 20'h88888;
    tick(); idle(); #1;
    check("waw8Clear", 32'(busyVector), 32'h0);

    // Store issue never marks its destination busy.
    issueValid = 1; issueWritesReg = 0; issueDest = 4'd6;
    tick();
    idle(); #1;
    check("storeBusy", 32'(busyVector), 32'h0);
    issueValid = 1; readAddrA = 4'd6; #1;
    check("storeNoStall", 32'(stall), 32'h0);

    // Simultaneous write-back and accepted issue to r7: set wins.
    idle();
    writeBackEnable = 1; writeBackAddress = 4'd7; writeBackData = 20'h77777;
    issueValid = 1; issueWritesReg = 1; issueDest = 4'd7; #1;
    check("sim7Stall", 32'(stall), 32'h0);
    tick();
    idle(); readAddrA = 4'd7; #1;
    check("sim7Busy", 32'(busyVector), 32'h0080);
    check("sim7Data", 32'(readDataA), 32'h77777);
    writeBackEnable = 1; writeBackAddress = 4'd7; writeBackData = 20'h07070;
    tick(); idle(); #1;
    check("sim7Clear", 32'(busyVector), 32'h0);

    // Same-cycle read of a register being written.
    readAddrA = 4'd2;
    writeBackEnable = 1; writeBackAddress = 4'd2; writeBackData = 20'h12345; #1;
    check("byp2Same", 32'(readDataA), BYP ? 32'h12345 : 32'h0);
    tick();
    writeBackEnable = 0; #1;
    check("byp2Next", 32'(readDataA), 32'h12345);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
